// File: rtl/aes_pkg.sv
// Shared AES constants and the control-state encoding used by the byte-serial
// SubBytes-family blocks.
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } aes_fsm_t;

endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box: one byte in, one byte out.
module inv_sbox (
  input  logic [7:0] value,
  output logic [7:0] result
);

  logic [127:0] row;
  logic [6:0]   shift;

  // Each row holds 16 table entries, column 0 in the most significant byte.
  always_comb begin
    row = '0;
    case (value[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      4'hf: row = 128'h172b047eba77d626e169146355210c7d;
      default: row = '0;
    endcase
  end

  assign shift  = {~value[3:0], 3'b000};
  assign result = row[shift +: 8];

endmodule

// File: rtl/inv_subbytes.sv
// Byte-serial AES InvSubBytes: captures the state on an accepted start and
// substitutes BYTES_PER_CYCLE bytes per cycle into state_out.
// Handshake: start is accepted only when busy is low; done then stays high
// with state_out stable until the next accepted start clears both.
module inv_subbytes
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [AES_BLOCK_W-1:0] state_in,
  output logic [AES_BLOCK_W-1:0] state_out,
  output logic                   busy,
  output logic                   done
);

  localparam int B     = BYTES_PER_CYCLE;
  localparam int N     = AES_NUM_BYTES / B;
  localparam int GW    = 8 * B;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_width
    $error("inv_subbytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  aes_fsm_t               state_q, state_d;
  logic                   accept;
  logic                   last_group;
  logic [IDX_W-1:0]       idx_q;
  logic [AES_BLOCK_W-1:0] cap_q;
  logic [AES_BLOCK_W-1:0] out_q;
  logic [AES_BLOCK_W-1:0] out_d;
  logic [GW-1:0]          group_in;
  logic [GW-1:0]          group_out;

  assign accept     = start && (state_q != RUN);
  assign last_group = (idx_q == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_group) state_d = FIN;
      FIN:     if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FIN);
  end

  always_comb begin
    group_in = '0;
    for (int n = 0; n < N; n++) begin
      if (idx_q == IDX_W'(n)) group_in = cap_q[n*GW +: GW];
    end
  end

  for (genvar g = 0; g < B; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .value  (group_in[8*g +: 8]),
      .result (group_out[8*g +: 8])
    );
  end

  // Only the lanes of the current group change; later lanes keep reading 0.
  always_comb begin
    out_d = out_q;
    for (int n = 0; n < N; n++) begin
      if (idx_q == IDX_W'(n)) out_d[n*GW +: GW] = group_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q <= '0;
      out_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      cap_q <= state_in;
      out_q <= '0;
      idx_q <= '0;
    end else if (state_q == RUN) begin
      out_q <= out_d;
      if (!last_group) idx_q <= idx_q + 1'b1;
    end
  end

  assign state_out = out_q;

endmodule

// File: tb/tb_inv_subbytes.sv
// Directed bench for inv_subbytes at 1, 4 and 16 bytes per cycle, plus a
// forward-S-box round trip on random states.
module tb_inv_subbytes;

  logic         clk;
  logic         rst_n;
  logic         start1, start4, start16;
  logic [127:0] in1, in4, in16;
  logic [127:0] out1, out4, out16;
  logic         busy1, busy4, busy16;
  logic         done1, done4, done16;

  int checks;
  int errors;

  inv_subbytes #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .state_in(in1),
    .state_out(out1), .busy(busy1), .done(done1)
  );
  inv_subbytes #(.BYTES_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .state_in(in4),
    .state_out(out4), .busy(busy4), .done(done4)
  );
  inv_subbytes #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .state_in(in16),
    .state_out(out16), .busy(busy16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Forward AES S-box, used only to build round-trip stimulus.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [127:0] row;
    case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return 8'(row >> {~a[3:0], 3'b000});
  endfunction

  task automatic set_in(input int w, input logic [127:0] s);
    case (w)
      1:       in1  = s;
      4:       in4  = s;
      default: in16 = s;
    endcase
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      1:       start1  = v;
      4:       start4  = v;
      default: start16 = v;
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      1:       return done1;
      4:       return done4;
      default: return done16;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      1:       return busy1;
      4:       return busy4;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [127:0] get_out(input int w);
    case (w)
      1:       return out1;
      4:       return out4;
      default: return out16;
    endcase
  endfunction

  // Counts edges after the start edge until done, bounded at 40.
  task automatic wait_done(input int w, output int n);
    n = 0;
    while (get_done(w) !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic run_pass(input int w, input logic [127:0] s, input int exp_lat,
                          input logic [127:0] exp_out, input string tag);
    int n;
    set_in(w, s);
    set_start(w, 1'b1);
    tick;
    set_start(w, 1'b0);
    chk({tag, "_busy"}, 128'(get_busy(w)), 128'd1);
    wait_done(w, n);
    chk({tag, "_lat"}, 128'(n), 128'(exp_lat));
    chk({tag, "_out"}, get_out(w), exp_out);
    chk({tag, "_idle"}, 128'(get_busy(w)), 128'd0);
  endtask

  localparam logic [127:0] PAT_MIX = {8'hED, {14{8'h00}}, 8'h16} >> 0;

  initial begin
    logic [127:0] mix_in, mix_out, orig, fwd;
    logic [7:0]   b;
    int           n, done_seen;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    {start1, start4, start16} = '0;
    in1 = '0; in4 = '0; in16 = '0;
    mix_in  = {8'h16, {14{8'h00}}, 8'hED};
    mix_out = {8'hFF, {14{8'h52}}, 8'h53};

    tick;
    tick;
    rst_n = 1'b1;
    chk("rst_out1", out1, '0);
    chk("rst_busy1", 128'(busy1), '0);
    chk("rst_done1", 128'(done1), '0);
    chk("rst_out4", out4, '0);
    chk("rst_done4", 128'(done4), '0);
    chk("rst_out16", out16, '0);
    chk("rst_done16", 128'(done16), '0);

    run_pass(1, {16{8'h63}}, 16, '0, "b1_all63");
    run_pass(1, mix_in, 16, mix_out, "b1_mix");

    // Partial progress: only lane 0 written after the first RUN edge.
    in1 = '0;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk("b1_fin_restart_done", 128'(done1), '0);
    chk("b1_fin_restart_out", out1, '0);
    tick;
    chk("b1_partial", out1, 128'h52);
    wait_done(1, n);
    chk("b1_all00_lat", 128'(n), 128'd15);
    chk("b1_all00_out", out1, {16{8'h52}});

    // start held and state_in changed during RUN must not disturb the pass.
    in1 = {16{8'h7c}};
    start1 = 1'b1;
    tick;
    in1 = '0;
    for (int i = 0; i < 5; i++) tick;
    start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      tick;
    end
    wait_done(1, n);
    chk("b1_hold_lat", 128'(n), 128'd5);
    chk("b1_hold_out", out1, {16{8'h01}});
    tick;
    tick;
    chk("b1_stable", out1, {16{8'h01}});

    // Abandon a pass with reset after seven RUN edges.
    in1 = {16{8'h00}};
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst_out", out1, '0);
    chk("midrst_busy", 128'(busy1), '0);
    chk("midrst_done", 128'(done1), '0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done1 !== 1'b0) done_seen++;
    end
    chk("midrst_no_done", 128'(done_seen), '0);
    run_pass(1, {16{8'h09}}, 16, {16{8'h40}}, "b1_after_rst");

    run_pass(4, {16{8'h63}}, 4, '0, "b4_all63");
    run_pass(4, '0, 4, {16{8'h52}}, "b4_all00");
    run_pass(4, mix_in, 4, mix_out, "b4_mix");
    run_pass(16, {16{8'h63}}, 1, '0, "b16_all63");
    run_pass(16, '0, 1, {16{8'h52}}, "b16_all00");
    run_pass(16, mix_in, 1, mix_out, "b16_mix");

    for (int v = 0; v < 1000; v++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      fwd = '0;
      for (int k = 0; k < 16; k++) begin
        b = 8'(orig >> (8 * k));
        fwd = fwd | (128'(sbox_f(b)) << (8 * k));
      end
      in1 = fwd;
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      wait_done(1, n);
      chk("round_trip", out1, orig);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
